cache_mem_arbiter: RTL and testbench

//  Shares the single unified main memory between the I-cache fill path and the D-cache

---
 rtl/cache_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one fixed-latency line memory between the
// I-cache fill path and the D-cache fill/write-back path.
//
// Ports:
//   clk, rst           clock; async active-high reset
//   i_req/i_addr       I-cache line read request (held until i_rdy)
//   i_rdy/i_rdata      one-cycle completion pulse / read line (held)
//   d_re/d_we/d_addr   D-cache line read or write request (held until d_rdy)
//   d_wdata            D-cache write line
//   d_rdy/d_rdata      one-cycle completion pulse / read line (held)
//   mem_re/mem_we      memory strobes, high for the whole access
//   mem_addr/wdata     memory line address / write line
//   mem_rdata          memory read line, valid in last access cycle
//   busy               high while an access is in ACCESS or DONE
module cache_mem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  // last_d / gnt_d: 1 = D side, 0 = I side
  logic last_d, last_d_n;
  logic gnt_d, gnt_d_n;
  logic wr, wr_n;
  logic mem_re_n, mem_we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic i_rdy_n, d_rdy_n;
  logic [DATA_W-1:0] i_rdata_n, d_rdata_n;
  logic busy_n;

  logic d_req, pick_d, pick_w;

  assign d_req  = d_re | d_we;
  // On conflict the side that did not win last time goes first.
  assign pick_d = d_req & (~i_req | ~last_d);
  // d_we wins over d_re when both are raised.
  assign pick_w = pick_d & d_we;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_d_n  = last_d;
    gnt_d_n   = gnt_d;
    wr_n      = wr;
    mem_re_n  = mem_re;
    mem_we_n  = mem_we;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    i_rdy_n   = 1'b0;
    d_rdy_n   = 1'b0;
    i_rdata_n = i_rdata;
    d_rdata_n = d_rdata;
    unique case (state)
      IDLE: begin
        if (i_req | d_req) begin
          gnt_d_n  = pick_d;
          last_d_n = pick_d;
          wr_n     = pick_w;
          addr_n   = pick_d ? d_addr : i_addr;
          if (pick_w)
            wdata_n = d_wdata;
          mem_re_n = ~pick_w;
          mem_we_n = pick_w;
          cnt_n    = LAT_M1;
          state_n  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          mem_re_n = 1'b0;
          mem_we_n = 1'b0;
          if (!wr) begin
            if (gnt_d)
              d_rdata_n = mem_rdata;
            else
              i_rdata_n = mem_rdata;
          end
          i_rdy_n = ~gnt_d;
          d_rdy_n = gnt_d;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      gnt_d     <= 1'b0;
      wr        <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdy     <= 1'b0;
      d_rdy     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_d    <= last_d_n;
      gnt_d     <= gnt_d_n;
      wr        <= wr_n;
      mem_re    <= mem_re_n;
      mem_we    <= mem_we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      i_rdy     <= i_rdy_n;
      d_rdy     <= d_rdy_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed self-checking bench for
// cache_mem_arbiter with MEM_LAT = 4.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [13:0] i_addr;
  logic        i_rdy;
  logic [63:0] i_rdata;
  logic        d_re, d_we;
  logic [13:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_rdy;
  logic [63:0] d_rdata;
  logic        mem_re, mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RD1 = 64'hDEAD_BEEF_0000_1234;
  localparam logic [63:0] WD1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WD2 = 64'h5555_AAAA_5555_AAAA;
  localparam logic [63:0] RD2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RD3 = 64'hCAFE_F00D_0BAD_0003;
  localparam logic [63:0] RD4 = 64'h0000_0000_0000_0044;
  localparam logic [63:0] WD3 = 64'hFEED_FACE_1357_9BDF;
  localparam logic [63:0] RD5 = 64'h9999_8888_7777_6666;

  cache_mem_arbiter #(
    .ADDR_W(14), .DATA_W(64), .MEM_LAT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_re(d_re), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1ns after the sampling edge; returns in the rdy cycle.
  task automatic access(input bit side_d, input bit wr,
                        input logic [13:0] addr,
                        input logic [63:0] wd,
                        input logic [63:0] rd);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("acc%0d_mem_re", k), 64'(mem_re), 64'(!wr));
      chk($sformatf("acc%0d_mem_we", k), 64'(mem_we), 64'(wr));
      chk($sformatf("acc%0d_addr", k), 64'(mem_addr), 64'(addr));
      if (wr)
        chk($sformatf("acc%0d_wdata", k), mem_wdata, wd);
      chk($sformatf("acc%0d_busy", k), 64'(busy), 64'd1);
      chk($sformatf("acc%0d_rdy", k), 64'({i_rdy, d_rdy}), 64'd0);
      step();
    end
    chk("done_i_rdy", 64'(i_rdy), 64'(!side_d));
    chk("done_d_rdy", 64'(d_rdy), 64'(side_d));
    chk("done_strobes", 64'({mem_re, mem_we}), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
    if (!wr) begin
      if (side_d)
        chk("done_d_rdata", d_rdata, rd);
      else
        chk("done_i_rdata", i_rdata, rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_re = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    step();
    step();
    chk("rst_strobes", 64'({mem_re, mem_we}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_rdy", 64'({i_rdy, d_rdy}), 64'd0);
    chk("rst_i_rdata", i_rdata, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // I-cache read
    i_req = 1'b1; i_addr = 14'h0010; mem_rdata = RD1;
    step();
    access(1'b0, 1'b0, 14'h0010, '0, RD1);
    i_req = 1'b0;
    step();
    chk("iread_rdy_drop", 64'(i_rdy), 64'd0);
    chk("iread_idle", 64'(busy), 64'd0);

    // D-cache write; d_rdata must stay untouched
    d_we = 1'b1; d_addr = 14'h0200; d_wdata = WD1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    access(1'b1, 1'b1, 14'h0200, WD1, '0);
    chk("dwr_d_rdata_kept", d_rdata, 64'd0);
    chk("dwr_i_rdata_kept", i_rdata, RD1);
    d_we = 1'b0;
    step();
    chk("dwr_rdy_drop", 64'(d_rdy), 64'd0);

    // Reset while a D write is in ACCESS with cnt = 2
    d_we = 1'b1; d_addr = 14'h0300; d_wdata = WD2;
    step();
    step();
    chk("mid_we_before", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_we", 64'(mem_we), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_addr", 64'(mem_addr), 64'd0);
    chk("mid_i_rdata", i_rdata, 64'd0);
    d_we = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("mid_quiet%0d", k),
          64'({d_rdy, i_rdy, busy, mem_we}), 64'd0);
    end

    // First conflict after reset: D first
    i_req = 1'b1; i_addr = 14'h0040;
    d_re = 1'b1; d_addr = 14'h0080; mem_rdata = RD2;
    step();
    access(1'b1, 1'b0, 14'h0080, '0, RD2);
    d_re = 1'b0;
    step();
    chk("c1_rdy_drop", 64'(d_rdy), 64'd0);
    chk("c1_idle", 64'(busy), 64'd0);

    // D re-requests against the waiting I: I wins now
    d_re = 1'b1; d_addr = 14'h0081; mem_rdata = RD3;
    step();
    access(1'b0, 1'b0, 14'h0040, '0, RD3);
    chk("c2_d_rdata_kept", d_rdata, RD2);
    i_req = 1'b0;
    step();
    chk("c2_rdy_drop", 64'(i_rdy), 64'd0);

    // Waiting D is granted next; it holds d_re across its rdy edge
    mem_rdata = RD4;
    step();
    access(1'b1, 1'b0, 14'h0081, '0, RD4);
    step();
    chk("hold_rdy_drop", 64'(d_rdy), 64'd0);
    chk("hold_idle", 64'(busy), 64'd0);
    d_re = 1'b0;
    step();
    chk("hold_no_regrant", 64'({busy, mem_re, d_rdy}), 64'd0);
    step();
    chk("hold_quiet", 64'({busy, d_rdy}), 64'd0);
    chk("hold_i_rdata", i_rdata, RD3);

    // d_re and d_we together: write only
    d_re = 1'b1; d_we = 1'b1;
    d_addr = 14'h0155; d_wdata = WD3; mem_rdata = RD5;
    step();
    access(1'b1, 1'b1, 14'h0155, WD3, '0);
    chk("both_d_rdata_kept", d_rdata, RD4);
    step();
    chk("both_rdy_drop", 64'(d_rdy), 64'd0);
    d_re = 1'b0; d_we = 1'b0;
    step();
    chk("both_idle", 64'({busy, mem_re, mem_we}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
